spi_prog_host: RTL and testbench
================================

SPI_PROG_HOST -- requirements
Module: spi_prog_host

Interface
REQ-001 Parameter CLK_DIV, default 4: SCK half-period in clk_i cycles; legal range 1..255.
REQ-002 Parameter CSB_GAP, default 16: clk_i cycles CSB is held high between byte frames; legal range 4..255.
REQ-003 clk_i  in  1  single block clock.
REQ-004 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 start_i  in  1  single-cycle request to begin a session; ignored while busy_o=1.
REQ-006 cmd_i  in  8  command byte, latched on an accepted start_i: 0xB1 ICCM, 0xB2 flash, 0xB3 QSPI config, other values mean command only.
REQ-007 wdata_i  in  32  payload word.
REQ-008 wvalid_i  in  1  payload word valid.
REQ-009 wlast_i  in  1  marks the final payload word; qualified by wvalid_i.
REQ-010 wready_o  out  1  payload word accepted when wvalid_i&wready_o.
REQ-011 sck_o  out  1  SPI clock; idles low.
REQ-012 sdo_o  out  1  serial data to the target sdi.
REQ-013 csb_o  out  1  active-low chip select; one frame per byte.
REQ-014 busy_o  out  1  session in progress.
REQ-015 done_o  out  1  one-cycle pulse when a session ends.
REQ-016 err_o  out  1  sticky flag: a payload word equal to 0x00FFFF00 was accepted.

Function
REQ-017 All outputs are registered; there are no combinational paths from inputs to outputs, except wready_o, which is decoded from state only.
REQ-018 FSM states: IDLE, SHIFT, GAP, NEXT, DONE.
REQ-019 IDLE: csb_o=1, sck_o=0, wready_o=0, busy_o=0; start_i=1 latches cmd_i, loads the shift byte with cmd_i, clears err_o and moves to SHIFT.
REQ-020 Latency: csb_o falls, and sdo_o=cmd_i[0], in the first cycle after start_i is sampled.
REQ-021 SHIFT: csb_o=0; bits are sent LSB first; each bit is CLK_DIV cycles of sck_o=0 followed by CLK_DIV cycles of sck_o=1.
REQ-022 sdo_o changes only in the cycle sck_o goes low and is stable for the whole high phase; a frame is exactly 16*CLK_DIV cycles of csb_o=0.
REQ-023 After the 8th high phase: csb_o=1 and sck_o=0 in the same cycle, then go to GAP.
REQ-024 GAP holds csb_o=1 for exactly CSB_GAP cycles, then goes to NEXT.
REQ-025 Words are sent as 4 frames, little-endian: byte0=[7:0] first, byte3=[31:24] last.
REQ-026 NEXT, case 1: while bytes of the current word remain, load the next byte and go to SHIFT.
REQ-027 NEXT, case 2: cmd is 0xB1/0xB2 and the terminator has not yet been sent: assert wready_o and wait for wvalid_i, with csb_o held high indefinitely.
REQ-028 NEXT, case 3: when a word is accepted, load it; on wlast_i, mark the terminator as pending.
REQ-029 NEXT, case 4: when the terminator is pending, load 0x00FFFF00 without asserting wready_o.
REQ-030 NEXT, case 5: after the terminator frames, go to DONE.
REQ-031 cmd 0xB3: accept exactly one word (wlast_i ignored), send it with no terminator, then go to DONE.
REQ-032 Any other cmd: the session is the command frame only, then DONE.
REQ-033 An accepted word equal to 0x00FFFF00 sets err_o; it is still transmitted unchanged, and err_o holds until the next accepted start_i.
REQ-034 DONE: done_o=1 for one cycle, busy_o=0 from the next cycle, return to IDLE.
REQ-035 busy_o=1 from the cycle after an accepted start_i through DONE inclusive.
REQ-036 At most one word is accepted per visit to NEXT; wready_o is never high outside NEXT.

Reset
REQ-037 While rst_ni=0, and in the first cycle after it releases, outputs are: csb_o=1, sck_o=0, sdo_o=0, wready_o=0, busy_o=0, done_o=0, err_o=0, FSM=IDLE.
REQ-038 Reset asserted mid-frame raises csb_o and drops sck_o immediately (asynchronously); no partial frame resumes after reset releases.
REQ-039 All counters, the latched cmd and the terminator-pending flag clear to 0 on reset.

Verification
REQ-040 CLK_DIV=4, CSB_GAP=16, cmd 0xB1, one word 0x12345678 with wlast_i=1 -> 9 frames. Bytes: B1, 78, 56, 34, 12, 00, FF, FF, 00. Each frame has 64 low cycles of csb_o. Gaps are 16 cycles. done_o pulses once.
REQ-041 cmd 0xB3, word 0xA5A5000F -> frames B3, 0F, 00, A5, A5; no terminator; wready_o is high for exactly one handshake.
REQ-042 cmd 0xB1, wvalid_i withheld 100 cycles after the command frame -> csb_o stays 1, sck_o stays 0, busy_o stays 1; transfer resumes on wvalid_i.
REQ-043 Word 0x00FFFF00 sent non-last -> err_o=1, the word is transmitted; the next start_i clears err_o.
REQ-044 Bit check: a bench shift register sampling sdo_o on sck_o posedge, LSB first, reconstructs every byte. start_i while busy_o=1 has no effect.
REQ-045 rst_ni pulsed low in the 3rd bit of a frame -> csb_o=1 and sck_o=0 immediately; after release, state is IDLE and no sck_o edges occur until start_i.

Source files
------------

// File: rtl/spi_prog_host.sv
// SPI programming host: sends a command byte and, for streaming or config
// commands, 32-bit payload words as little-endian byte frames. Streaming
// sessions close with a 0x00FFFF00 terminator word.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | csb high, waiting for start_i
// SHIFT  | csb low, shifting one byte LSB first on sck
// GAP    | csb high between frames
// NEXT   | choose next byte / fetch next word / terminator / finish
// DONE   | one-cycle done pulse, then back to IDLE
module spi_prog_host #(
    parameter int CLK_DIV = 4,
    parameter int CSB_GAP = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  cmd_i,
    input  logic [31:0] wdata_i,
    input  logic        wvalid_i,
    input  logic        wlast_i,
    output logic        wready_o,
    output logic        sck_o,
    output logic        sdo_o,
    output logic        csb_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_NEXT, ST_DONE} state_t;

    localparam logic [31:0] TERM_WORD = 32'h00FF_FF00;
    localparam logic [7:0]  DIV_LOAD  = 8'(CLK_DIV - 1);
    // The single NEXT cycle also has csb high, so GAP itself lasts one
    // cycle less than CSB_GAP to keep the csb-high time exact.
    localparam logic [7:0]  GAP_LOAD  = 8'(CSB_GAP - 2);

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  shift_q, shift_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  bytes_left_q, bytes_left_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  gap_q, gap_d;
    logic        term_pend_q, term_pend_d;
    logic        term_sent_q, term_sent_d;
    logic        word_got_q, word_got_d;
    logic        sck_q, sck_d, sdo_q, sdo_d, csb_q, csb_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic        is_stream, is_cfg, need_word;
    logic        frame_start;
    logic [7:0]  frame_byte;

    assign is_stream = (cmd_q == 8'hB1) || (cmd_q == 8'hB2);
    assign is_cfg    = (cmd_q == 8'hB3);
    assign need_word = (state_q == ST_NEXT) && (bytes_left_q == 2'd0) &&
                       ((is_stream && !term_pend_q && !term_sent_q) ||
                        (is_cfg && !word_got_q));

    assign wready_o = need_word;
    assign sck_o    = sck_q;
    assign sdo_o    = sdo_q;
    assign csb_o    = csb_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        shift_d      = shift_q;
        word_d       = word_q;
        bytes_left_d = bytes_left_q;
        bit_d        = bit_q;
        div_d        = div_q;
        gap_d        = gap_q;
        term_pend_d  = term_pend_q;
        term_sent_d  = term_sent_q;
        word_got_d   = word_got_q;
        sck_d        = sck_q;
        sdo_d        = sdo_q;
        csb_d        = csb_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        frame_start  = 1'b0;
        frame_byte   = 8'h00;

        case (state_q)
            ST_IDLE: begin
                csb_d  = 1'b1;
                sck_d  = 1'b0;
                busy_d = 1'b0;
                if (start_i) begin
                    cmd_d        = cmd_i;
                    err_d        = 1'b0;
                    term_pend_d  = 1'b0;
                    term_sent_d  = 1'b0;
                    word_got_d   = 1'b0;
                    bytes_left_d = 2'd0;
                    busy_d       = 1'b1;
                    frame_start  = 1'b1;
                    frame_byte   = cmd_i;
                end
            end
            ST_SHIFT: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else if (!sck_q) begin
                    sck_d = 1'b1;
                    div_d = DIV_LOAD;
                end else if (bit_q == 3'd7) begin
                    sck_d   = 1'b0;
                    csb_d   = 1'b1;
                    gap_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    sck_d   = 1'b0;
                    bit_d   = bit_q + 3'd1;
                    sdo_d   = shift_q[1];
                    shift_d = {1'b0, shift_q[7:1]};
                    div_d   = DIV_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
                else               state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (bytes_left_q != 2'd0) begin
                    frame_start  = 1'b1;
                    frame_byte   = word_q[7:0];
                    word_d       = {8'h00, word_q[23:8]};
                    bytes_left_d = bytes_left_q - 2'd1;
                end else if (need_word) begin
                    if (wvalid_i) begin
                        frame_start  = 1'b1;
                        frame_byte   = wdata_i[7:0];
                        word_d       = wdata_i[31:8];
                        bytes_left_d = 2'd3;
                        word_got_d   = 1'b1;
                        if (is_stream)              term_pend_d = wlast_i;
                        if (wdata_i == TERM_WORD)   err_d       = 1'b1;
                    end
                end else if (is_stream && term_pend_q) begin
                    frame_start  = 1'b1;
                    frame_byte   = TERM_WORD[7:0];
                    word_d       = TERM_WORD[31:8];
                    bytes_left_d = 2'd3;
                    term_pend_d  = 1'b0;
                    term_sent_d  = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                sdo_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_start) begin
            shift_d = frame_byte;
            sdo_d   = frame_byte[0];
            csb_d   = 1'b0;
            sck_d   = 1'b0;
            bit_d   = 3'd0;
            div_d   = DIV_LOAD;
            state_d = ST_SHIFT;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cmd_q        <= 8'h00;
            shift_q      <= 8'h00;
            word_q       <= 24'h0;
            bytes_left_q <= 2'd0;
            bit_q        <= 3'd0;
            div_q        <= 8'd0;
            gap_q        <= 8'd0;
            term_pend_q  <= 1'b0;
            term_sent_q  <= 1'b0;
            word_got_q   <= 1'b0;
            sck_q        <= 1'b0;
            sdo_q        <= 1'b0;
            csb_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            bytes_left_q <= bytes_left_d;
            bit_q        <= bit_d;
            div_q        <= div_d;
            gap_q        <= gap_d;
            term_pend_q  <= term_pend_d;
            term_sent_q  <= term_sent_d;
            word_got_q   <= word_got_d;
            sck_q        <= sck_d;
            sdo_q        <= sdo_d;
            csb_q        <= csb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_spi_prog_host.sv
// Bench for spi_prog_host: table of whole sessions plus hand-written
// sequences for payload stalls, the error word and mid-frame reset.
module tb_spi_prog_host;

    localparam int CLK_DIV = 4;
    localparam int CSB_GAP = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  cmd_i = 8'h00;
    logic [31:0] wdata_i = 32'h0;
    logic        wvalid_i = 1'b0;
    logic        wlast_i = 1'b0;
    logic        wready_o, sck_o, sdo_o, csb_o, busy_o, done_o, err_o;

    spi_prog_host #(.CLK_DIV(CLK_DIV), .CSB_GAP(CSB_GAP)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .cmd_i(cmd_i),
        .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wlast_i(wlast_i),
        .wready_o(wready_o), .sck_o(sck_o), .sdo_o(sdo_o), .csb_o(csb_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit-level receiver: sample sdo on every sck rise inside a frame.
    logic [7:0] sh = 8'h00;
    int bitn = 0;
    int sck_rise = 0;
    always @(posedge sck_o) begin
        sck_rise++;
        if (!csb_o) begin
            sh = {sdo_o, sh[7:1]};
            bitn++;
        end
    end

    // Frame monitor: bytes, frame lengths, gaps, pulses, handshakes.
    logic [7:0] rx_q[$];
    int gap_q[$];
    int low_cnt = 0, high_cnt = 0, bit_base = 0;
    int bad_len = 0, done_cnt = 0, hs_cnt = 0, sdo_glitch = 0;
    bit have_prev = 1'b0;
    logic prev_csb = 1'b1, prev_sck = 1'b0, prev_sdo = 1'b0;
    always @(negedge clk_i) begin
        if (wready_o && wvalid_i) hs_cnt++;
        if (done_o) done_cnt++;
        if (sck_o && prev_sck && (sdo_o !== prev_sdo)) sdo_glitch++;
        if (!csb_o) begin
            if (prev_csb && have_prev) gap_q.push_back(high_cnt);
            low_cnt++;
        end else if (!prev_csb) begin
            rx_q.push_back(sh);
            if (low_cnt != 16*CLK_DIV || (bitn - bit_base) != 8) bad_len++;
            bit_base  = bitn;
            low_cnt   = 0;
            have_prev = 1'b1;
            high_cnt  = 1;
        end else begin
            high_cnt++;
        end
        if (!busy_o) have_prev = 1'b0;
        prev_csb = csb_o;
        prev_sck = sck_o;
        prev_sdo = sdo_o;
    end

    typedef struct {
        logic [7:0]       cmd;
        logic [31:0]      word;
        bit               has_word;
        bit               poke;
        int               nbytes;
        logic [8:0][7:0]  exp;
        int               exp_hs;
        logic             exp_err;
    } vec_t;

    vec_t vecs[6];

    int rx_base, gap_base, len_base, done_base, hs_base, gl_base;

    task automatic take_bases();
        rx_base  = rx_q.size();
        gap_base = gap_q.size();
        len_base = bad_len;
        done_base = done_cnt;
        hs_base  = hs_cnt;
        gl_base  = sdo_glitch;
    endtask

    task automatic pulse_start(input logic [7:0] c);
        cmd_i   = c;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        cmd_i   = 8'h00;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (wready_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic l);
        bit ok;
        wait_ready(ok);
        chk("wready_timeout", ok, 1'b1);
        if (ok) begin
            wdata_i  = w;
            wlast_i  = l;
            wvalid_i = 1'b1;
            @(posedge clk_i); #1;
            wvalid_i = 1'b0;
            wlast_i  = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (done_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
        chk("done_timeout", ok, 1'b1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
    endtask

    logic [12:0][7:0] e13;
    bit stall_bad;
    int rise_base;

    initial begin
        vecs[0] = '{8'hB1, 32'h1234_5678, 1'b1, 1'b0, 9,
                    {8'h00, 8'hFF, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'hB1}, 1, 1'b0};
        vecs[1] = '{8'hB3, 32'hA5A5_000F, 1'b1, 1'b1, 5,
                    {8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'h0F, 8'hB3}, 1, 1'b0};
        vecs[2] = '{8'h42, 32'h0, 1'b0, 1'b1, 1,
                    {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h42}, 0, 1'b0};
        vecs[3] = '{8'hB2, 32'hDEAD_BEEF, 1'b1, 1'b0, 9,
                    {8'h00, 8'hFF, 8'hFF, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hB2}, 1, 1'b0};
        vecs[4] = '{8'hB1, 32'h00FF_FF00, 1'b1, 1'b0, 9,
                    {8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hB1}, 1, 1'b1};
        vecs[5] = '{8'hB0, 32'h0, 1'b0, 1'b0, 1,
                    {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB0}, 0, 1'b0};

        // Reset values while held and in the first cycle after release.
        #22;
        chk("rst_csb", csb_o, 1'b1);
        chk("rst_sck", sck_o, 1'b0);
        chk("rst_sdo", sdo_o, 1'b0);
        chk("rst_busy_wready", {busy_o, wready_o, done_o, err_o}, 4'b0000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rel_csb_sck", {csb_o, sck_o}, 2'b10);
        chk("rel_busy_done", {busy_o, done_o, wready_o}, 3'b000);
        @(posedge clk_i); #1;

        // Table of complete sessions.
        for (int v = 0; v < 6; v++) begin
            take_bases();
            pulse_start(vecs[v].cmd);
            chk("lat_csb", csb_o, 1'b0);
            chk("lat_sdo", sdo_o, vecs[v].cmd[0]);
            chk("lat_busy", busy_o, 1'b1);
            if (vecs[v].poke) begin
                repeat (20) @(posedge clk_i);
                #1;
                pulse_start(8'h42);
            end
            if (vecs[v].has_word) push_word(vecs[v].word, 1'b1);
            wait_done();
            chk("n_bytes", rx_q.size() - rx_base, vecs[v].nbytes);
            for (int k = 0; k < vecs[v].nbytes; k++)
                chk($sformatf("byte%0d_v%0d", k, v), rx_q[rx_base + k], vecs[v].exp[k]);
            chk("n_gaps", gap_q.size() - gap_base, vecs[v].nbytes - 1);
            for (int k = gap_base; k < gap_q.size(); k++)
                chk("gap_len", gap_q[k], CSB_GAP);
            chk("frame_len", bad_len - len_base, 0);
            chk("sdo_stable", sdo_glitch - gl_base, 0);
            chk("done_pulses", done_cnt - done_base, 1);
            chk("handshakes", hs_cnt - hs_base, vecs[v].exp_hs);
            chk("err", err_o, vecs[v].exp_err);
            chk("busy_end", busy_o, 1'b0);
        end

        // Stalled payload, error word sent non-last, then a last word.
        take_bases();
        pulse_start(8'hB1);
        push_word(32'h0, 1'b0);
        begin
            bit ok;
            wait_ready(ok);
            chk("stall_ready", ok, 1'b1);
        end
        stall_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (csb_o !== 1'b1 || sck_o !== 1'b0 || busy_o !== 1'b1 || wready_o !== 1'b1)
                stall_bad = 1'b1;
            @(posedge clk_i); #1;
        end
        chk("stall_hold", stall_bad, 1'b0);
        wdata_i = 32'h00FF_FF00;
        wvalid_i = 1'b1;
        @(posedge clk_i); #1;
        wvalid_i = 1'b0;
        chk("err_set", err_o, 1'b1);
        push_word(32'h1122_3344, 1'b1);
        wait_done();
        e13 = {8'h00, 8'hFF, 8'hFF, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h00, 8'hFF, 8'hFF, 8'h00, 8'hB1};
        // The zero word pushed first was accepted right after the
        // command frame; the stall happened before the error word.
        chk("stall_nbytes", rx_q.size() - rx_base, 17);
        for (int k = 0; k < 4; k++)
            chk("stall_zero_word", rx_q[rx_base + 1 + k], 8'h00);
        chk("stall_cmd", rx_q[rx_base], 8'hB1);
        for (int k = 1; k < 13; k++)
            chk($sformatf("stall_byte%0d", k), rx_q[rx_base + 4 + k], e13[k]);
        chk("stall_hs", hs_cnt - hs_base, 3);
        chk("err_hold", err_o, 1'b1);
        pulse_start(8'h42);
        chk("err_clear", err_o, 1'b0);
        wait_done();

        // Reset pulsed during the third bit of a frame.
        rise_base = sck_rise;
        pulse_start(8'h5A);
        for (int i = 0; i < 500 && (sck_rise - rise_base) < 2; i++) begin
            @(posedge clk_i); #1;
        end
        repeat (CLK_DIV + 1) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_csb_sck", {csb_o, sck_o}, 2'b10);
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_mid_outs", {busy_o, done_o, wready_o, sdo_o, err_o}, 5'b00000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rel_mid_csb_sck", {csb_o, sck_o, busy_o}, 3'b100);
        rise_base = sck_rise;
        stall_bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (csb_o !== 1'b1 || busy_o !== 1'b0) stall_bad = 1'b1;
            @(posedge clk_i); #1;
        end
        chk("no_sck_after_rst", sck_rise - rise_base, 0);
        chk("idle_after_rst", stall_bad, 1'b0);

        // A fresh session still works after the reset.
        take_bases();
        pulse_start(8'h3C);
        wait_done();
        chk("post_rst_nbytes", rx_q.size() - rx_base, 1);
        chk("post_rst_byte", rx_q[rx_base], 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
